irq_ctrl: RTL and testbench

Parametrised multi-source machine interrupt controller. It is the successor to the single-input interrupter, generalised to NIRQ sources.
- Per-source enable, edge/level mode, priority, plus a global threshold.
- Claim/complete handshake over the IO register bus.
- Sits beside the dma IO window in cpu_top. Drives g_interrupt to ex_stage, gated by csr_meie.

---
 rtl/irq_ctrl_pkg.sv | 14 +
 rtl/irq_prio_arb.sv | 32 +++
 rtl/irq_ctrl.sv | 166 ++++++++++++++++
 tb/tb_irq_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared register map and ID width for the interrupt controller.
package irq_ctrl_pkg;

  localparam int unsigned ID_W  = 5;
  localparam int unsigned ADR_W = 6;

  localparam logic [ADR_W-1:0] ADR_ENABLE    = 6'h00;
  localparam logic [ADR_W-1:0] ADR_MODE      = 6'h01;
  localparam logic [ADR_W-1:0] ADR_PENDING   = 6'h02;
  localparam logic [ADR_W-1:0] ADR_THRESHOLD = 6'h03;
  localparam logic [ADR_W-1:0] ADR_CLAIM     = 6'h04;
  localparam logic [ADR_W-1:0] ADR_PRIO_BASE = 6'h10;

endpackage

// File: rtl/irq_prio_arb.sv
// Combinational selector: highest priority among eligible sources, ties to lowest ID.
module irq_prio_arb
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned NIRQ  = 8,
  parameter int unsigned PRI_W = 3
) (
  input  logic [NIRQ-1:0]            i_elig,
  input  logic [NIRQ-1:0][PRI_W-1:0] i_prio,
  output logic [ID_W-1:0]            o_id,
  output logic [PRI_W-1:0]           o_pri
);

  logic [ID_W-1:0]  w_best_id;
  logic [PRI_W-1:0] w_best_pri;

  // Scan from the highest ID down; >= lets a lower ID take over on equal priority
  always_comb begin
    w_best_id  = '0;
    w_best_pri = '0;
    for (int i = int'(NIRQ) - 1; i >= 0; i--) begin
      if (i_elig[i] && (i_prio[i] >= w_best_pri)) begin
        w_best_id  = ID_W'(i + 1);
        w_best_pri = i_prio[i];
      end
    end
  end

  assign o_id  = w_best_id;
  assign o_pri = w_best_pri;

endmodule

// File: rtl/irq_ctrl.sv
// Multi-source machine interrupt controller with claim/complete over the IO register bus.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned NIRQ        = 8,
  parameter int unsigned PRI_W       = 3,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NIRQ-1:0] irq_in,
  input  logic            csr_meie,
  input  logic            io_we,
  input  logic [7:2]      io_wadr,
  input  logic [31:0]     io_wdata,
  input  logic            io_re,
  input  logic [7:2]      io_radr,
  output logic [31:0]     io_rdata,
  output logic            g_interrupt,
  output logic [ID_W-1:0] irq_id
);

  logic [SYNC_STAGES-1:0][NIRQ-1:0] r_sync;
  logic [NIRQ-1:0]                  r_sync_d;
  logic [NIRQ-1:0]                  r_en;
  logic [NIRQ-1:0]                  r_mode;
  logic [NIRQ-1:0]                  r_pend;
  logic [NIRQ-1:0]                  r_insvc;
  logic [PRI_W-1:0]                 r_thr;
  logic [NIRQ-1:0][PRI_W-1:0]       r_prio;
  logic [31:0]                      r_rdata;
  logic                             r_irq;
  logic [ID_W-1:0]                  r_id;

  logic [NIRQ-1:0]  w_sync;
  logic [NIRQ-1:0]  w_rise;
  logic [NIRQ-1:0]  w_elig;
  logic [NIRQ-1:0]  w_claim_vec;
  logic [NIRQ-1:0]  w_cmpl_vec;
  logic [NIRQ-1:0]  w_w1c;
  logic [NIRQ-1:0]  w_insvc_nxt;
  logic [NIRQ-1:0]  w_pend_nxt;
  logic [31:0]      w_rdata;
  logic             w_claim;
  logic [ID_W-1:0]  w_win_id;
  logic [PRI_W-1:0] w_win_pri;
  logic             w_unused;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_rise = w_sync & ~r_sync_d;

  // Eligibility: pending, enabled, not in service, above threshold
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < int'(NIRQ); i++) begin
      w_elig[i] = r_pend[i] & r_en[i] & ~r_insvc[i] & (r_prio[i] > r_thr);
    end
  end

  irq_prio_arb #(
    .NIRQ  (NIRQ),
    .PRI_W (PRI_W)
  ) u_arb (
    .i_elig (w_elig),
    .i_prio (r_prio),
    .o_id   (w_win_id),
    .o_pri  (w_win_pri)
  );

  // Claim/complete decode and next pending/in-service state
  always_comb begin
    w_claim     = io_re && (io_radr == ADR_CLAIM) && (w_win_id != '0);
    w_claim_vec = '0;
    w_cmpl_vec  = '0;
    w_w1c       = '0;
    for (int i = 0; i < int'(NIRQ); i++) begin
      w_claim_vec[i] = w_claim && (w_win_id == ID_W'(i + 1));
      w_cmpl_vec[i]  = io_we && (io_wadr == ADR_CLAIM) &&
                       (io_wdata[ID_W-1:0] == ID_W'(i + 1));
    end
    if (io_we && (io_wadr == ADR_PENDING)) begin
      w_w1c = io_wdata[NIRQ:1] & r_mode;
    end
    // complete after claim so a same-cycle complete of the claimed ID wins
    w_insvc_nxt = (r_insvc | w_claim_vec) & ~w_cmpl_vec;
    // edge: a new rising edge beats any clear; level: follows the line unless in service
    w_pend_nxt  = (r_mode & (w_rise | (r_pend & ~w_w1c & ~w_claim_vec))) |
                  (~r_mode & w_sync & ~w_insvc_nxt);
  end

  // Register read mux
  always_comb begin
    w_rdata = '0;
    unique case (io_radr)
      ADR_ENABLE:    w_rdata = 32'({r_en, 1'b0});
      ADR_MODE:      w_rdata = 32'({r_mode, 1'b0});
      ADR_PENDING:   w_rdata = 32'({r_pend, 1'b0});
      ADR_THRESHOLD: w_rdata = 32'(r_thr);
      ADR_CLAIM:     w_rdata = 32'(w_win_id);
      default: begin
        for (int i = 0; i < int'(NIRQ); i++) begin
          if (io_radr == ADR_W'(int'(ADR_PRIO_BASE) + i + 1)) begin
            w_rdata = 32'(r_prio[i]);
          end
        end
      end
    endcase
  end

  // Input synchronisers and edge-detect history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '0;
      r_sync_d <= '0;
    end else begin
      r_sync[0] <= irq_in;
      for (int k = 1; k < int'(SYNC_STAGES); k++) begin
        r_sync[k] <= r_sync[k-1];
      end
      r_sync_d <= w_sync;
    end
  end

  // Configuration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en   <= '0;
      r_mode <= '0;
      r_thr  <= '0;
      r_prio <= '0;
    end else if (io_we) begin
      if (io_wadr == ADR_ENABLE)    r_en   <= io_wdata[NIRQ:1];
      if (io_wadr == ADR_MODE)      r_mode <= io_wdata[NIRQ:1];
      if (io_wadr == ADR_THRESHOLD) r_thr  <= io_wdata[PRI_W-1:0];
      for (int i = 0; i < int'(NIRQ); i++) begin
        if (io_wadr == ADR_W'(int'(ADR_PRIO_BASE) + i + 1)) begin
          r_prio[i] <= io_wdata[PRI_W-1:0];
        end
      end
    end
  end

  // Pending, in-service, read data and registered request outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend  <= '0;
      r_insvc <= '0;
      r_rdata <= '0;
      r_irq   <= 1'b0;
      r_id    <= '0;
    end else begin
      r_pend  <= w_pend_nxt;
      r_insvc <= w_insvc_nxt;
      if (io_re) r_rdata <= w_rdata;
      r_irq   <= csr_meie && (w_win_id != '0);
      r_id    <= w_win_id;
    end
  end

  assign io_rdata    = r_rdata;
  assign g_interrupt = r_irq;
  assign irq_id      = r_id;

  assign w_unused = ^{w_win_pri, io_wdata};

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: scenario tasks with a queue of expected read data.
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  localparam int unsigned NIRQ = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [NIRQ-1:0] irq_in;
  logic        csr_meie;
  logic        io_we;
  logic [7:2]  io_wadr;
  logic [31:0] io_wdata;
  logic        io_re;
  logic [7:2]  io_radr;
  logic [31:0] io_rdata;
  logic        g_interrupt;
  logic [4:0]  irq_id;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] q[$];
  logic [31:0] got, exp;

  always #5 clk = ~clk;

  irq_ctrl #(.NIRQ(NIRQ), .PRI_W(3), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .csr_meie(csr_meie),
    .io_we(io_we), .io_wadr(io_wadr), .io_wdata(io_wdata),
    .io_re(io_re), .io_radr(io_radr), .io_rdata(io_rdata),
    .g_interrupt(g_interrupt), .irq_id(irq_id)
  );

  // All stimulus changes and all sampling happen on the falling edge
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    io_we = 1'b1; io_wadr = a; io_wdata = d;
    @(negedge clk);
    io_we = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d);
    io_re = 1'b1; io_radr = a;
    @(negedge clk);
    io_re = 1'b0;
    d = io_rdata;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(2);
    n_tests++; if (g_interrupt !== 1'b0) begin n_fail++; $display("FAIL reset_g: g_interrupt=%b expected 0", g_interrupt); end
    n_tests++; if (irq_id !== 5'd0) begin n_fail++; $display("FAIL reset_id: irq_id=%0d expected 0", irq_id); end
    n_tests++; if (io_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: io_rdata=%0h expected 0", io_rdata); end
    rst_n = 1'b1;
    cyc(1);
    q.push_back(32'd0); rd(ADR_ENABLE, got); exp = q.pop_front();
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL reset_enable: got %0h expected %0h", got, exp); end
    q.push_back(32'd0); rd(ADR_THRESHOLD, got); exp = q.pop_front();
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL reset_thr: got %0h expected %0h", got, exp); end
  endtask

  task automatic test_edge();
    do_reset();
    wr(ADR_PRIO_BASE + 6'd3, 32'd5);
    wr(ADR_MODE, 32'h08);
    wr(ADR_ENABLE, 32'h08);
    irq_in[2] = 1'b1;
    cyc(1);
    irq_in[2] = 1'b0;
    cyc(2);
    n_tests++; if (g_interrupt !== 1'b0) begin n_fail++; $display("FAIL edge_early: g_interrupt=%b expected 0 at N+2", g_interrupt); end
    cyc(1);
    n_tests++; if (g_interrupt !== 1'b1) begin n_fail++; $display("FAIL edge_lat: g_interrupt=%b expected 1 at N+3", g_interrupt); end
    n_tests++; if (irq_id !== 5'd3) begin n_fail++; $display("FAIL edge_id: irq_id=%0d expected 3", irq_id); end
    q.push_back(32'd3); rd(ADR_CLAIM, got); exp = q.pop_front();
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL edge_claim: got %0d expected %0d", got, exp); end
    cyc(1);
    n_tests++; if (g_interrupt !== 1'b0) begin n_fail++; $display("FAIL edge_drop: g_interrupt=%b expected 0", g_interrupt); end
    irq_in[2] = 1'b1;
    cyc(1);
    irq_in[2] = 1'b0;
    cyc(3);
    q.push_back(32'h08); rd(ADR_PENDING, got); exp = q.pop_front();
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL edge_repend: got %0h expected %0h", got, exp); end
    n_tests++; if (g_interrupt !== 1'b0) begin n_fail++; $display("FAIL edge_insvc: g_interrupt=%b expected 0", g_interrupt); end
    wr(ADR_CLAIM, 32'd3);
    cyc(1);
    n_tests++; if (g_interrupt !== 1'b1 || irq_id !== 5'd3) begin n_fail++; $display("FAIL edge_reassert: g=%b id=%0d expected 1/3", g_interrupt, irq_id); end
  endtask

  task automatic test_arb();
    do_reset();
    wr(ADR_PRIO_BASE + 6'd1, 32'd2);
    wr(ADR_PRIO_BASE + 6'd4, 32'd7);
    wr(ADR_PRIO_BASE + 6'd6, 32'd7);
    wr(ADR_MODE, 32'h52);
    wr(ADR_ENABLE, 32'h52);
    irq_in = 8'b0010_1001;
    cyc(1);
    irq_in = '0;
    cyc(3);
    n_tests++; if (irq_id !== 5'd4 || g_interrupt !== 1'b1) begin n_fail++; $display("FAIL arb_win: id=%0d g=%b expected 4/1", irq_id, g_interrupt); end
    wr(ADR_THRESHOLD, 32'd7);
    cyc(1);
    n_tests++; if (g_interrupt !== 1'b0) begin n_fail++; $display("FAIL arb_thr: g_interrupt=%b expected 0", g_interrupt); end
    csr_meie = 1'b0;
    wr(ADR_THRESHOLD, 32'd0);
    cyc(1);
    n_tests++; if (g_interrupt !== 1'b0 || irq_id !== 5'd4) begin n_fail++; $display("FAIL arb_meie: g=%b id=%0d expected 0/4", g_interrupt, irq_id); end
    csr_meie = 1'b1;
    q.push_back(32'd4); q.push_back(32'd6); q.push_back(32'd1);
    for (int k = 0; k < 3; k++) begin
      rd(ADR_CLAIM, got); exp = q.pop_front();
      n_tests++; if (got !== exp) begin n_fail++; $display("FAIL arb_claim%0d: got %0d expected %0d", k, got, exp); end
    end
  endtask

  task automatic test_level();
    do_reset();
    wr(ADR_PRIO_BASE + 6'd2, 32'd3);
    wr(ADR_ENABLE, 32'h04);
    irq_in[1] = 1'b1;
    cyc(4);
    n_tests++; if (g_interrupt !== 1'b1 || irq_id !== 5'd2) begin n_fail++; $display("FAIL lvl_req: g=%b id=%0d expected 1/2", g_interrupt, irq_id); end
    q.push_back(32'd2); rd(ADR_CLAIM, got); exp = q.pop_front();
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL lvl_claim: got %0d expected %0d", got, exp); end
    q.push_back(32'd0); rd(ADR_PENDING, got); exp = q.pop_front();
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL lvl_insvc_pend: got %0h expected %0h", got, exp); end
    wr(ADR_CLAIM, 32'd2);
    q.push_back(32'h04); rd(ADR_PENDING, got); exp = q.pop_front();
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL lvl_repend: got %0h expected %0h", got, exp); end
    q.push_back(32'd2); rd(ADR_CLAIM, got); exp = q.pop_front();
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL lvl_claim2: got %0d expected %0d", got, exp); end
    irq_in[1] = 1'b0;
    cyc(3);
    wr(ADR_CLAIM, 32'd2);
    cyc(1);
    q.push_back(32'd0); rd(ADR_PENDING, got); exp = q.pop_front();
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL lvl_low: got %0h expected %0h", got, exp); end
    n_tests++; if (g_interrupt !== 1'b0) begin n_fail++; $display("FAIL lvl_low_g: g_interrupt=%b expected 0", g_interrupt); end
  endtask

  task automatic test_boundary();
    do_reset();
    q.push_back(32'd0); rd(ADR_CLAIM, got); exp = q.pop_front();
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL bnd_claim0: got %0d expected %0d", got, exp); end
    q.push_back(32'd0); rd(ADR_PENDING, got); exp = q.pop_front();
    n_tests++; if (got !== exp || g_interrupt !== 1'b0) begin n_fail++; $display("FAIL bnd_claim0_state: pend=%0h g=%b expected 0/0", got, g_interrupt); end
    wr(ADR_PRIO_BASE + 6'd5, 32'd4);
    wr(ADR_ENABLE, 32'h20);
    irq_in[4] = 1'b1;
    cyc(4);
    q.push_back(32'd5); rd(ADR_CLAIM, got); exp = q.pop_front();
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL bnd_claim5: got %0d expected %0d", got, exp); end
    cyc(1);
    wr(ADR_CLAIM, 32'd0);
    wr(ADR_CLAIM, 32'd9);
    wr(ADR_CLAIM, 32'd13);
    cyc(2);
    q.push_back(32'd0); rd(ADR_PENDING, got); exp = q.pop_front();
    n_tests++; if (got !== exp || g_interrupt !== 1'b0) begin n_fail++; $display("FAIL bnd_bad_cmpl: pend=%0h g=%b expected 0/0", got, g_interrupt); end
    wr(ADR_CLAIM, 32'd5);
    cyc(2);
    n_tests++; if (g_interrupt !== 1'b1 || irq_id !== 5'd5) begin n_fail++; $display("FAIL bnd_cmpl5: g=%b id=%0d expected 1/5", g_interrupt, irq_id); end
    // claim and complete of ID5 in the same cycle
    q.push_back(32'd5);
    io_re = 1'b1; io_radr = ADR_CLAIM;
    io_we = 1'b1; io_wadr = ADR_CLAIM; io_wdata = 32'd5;
    @(negedge clk);
    io_re = 1'b0; io_we = 1'b0;
    got = io_rdata; exp = q.pop_front();
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL bnd_cc_claim: got %0d expected %0d", got, exp); end
    q.push_back(32'h20); rd(ADR_PENDING, got); exp = q.pop_front();
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL bnd_cc_insvc: pend=%0h expected %0h", got, exp); end
    irq_in[4] = 1'b0;
    cyc(3);
    wr(ADR_MODE, 32'h20);
    wr(ADR_PENDING, 32'h20);
    q.push_back(32'd0); rd(ADR_PENDING, got); exp = q.pop_front();
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL bnd_w1c: pend=%0h expected %0h", got, exp); end
    // rising edge lands on the same clock edge as the W1C write
    irq_in[4] = 1'b1;
    cyc(1);
    irq_in[4] = 1'b0;
    cyc(1);
    wr(ADR_PENDING, 32'h20);
    q.push_back(32'h20); rd(ADR_PENDING, got); exp = q.pop_front();
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL bnd_set_wins: pend=%0h expected %0h", got, exp); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    wr(ADR_PRIO_BASE + 6'd3, 32'd6);
    wr(ADR_PRIO_BASE + 6'd4, 32'd2);
    wr(ADR_ENABLE, 32'h18);
    irq_in = 8'b0000_1100;
    cyc(4);
    q.push_back(32'd3); rd(ADR_CLAIM, got); exp = q.pop_front();
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL rst_claim: got %0d expected %0d", got, exp); end
    cyc(2);
    n_tests++; if (g_interrupt !== 1'b1 || irq_id !== 5'd4) begin n_fail++; $display("FAIL rst_pre: g=%b id=%0d expected 1/4", g_interrupt, irq_id); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (g_interrupt !== 1'b0 || irq_id !== 5'd0 || io_rdata !== 32'd0) begin n_fail++; $display("FAIL rst_async: g=%b id=%0d rdata=%0h expected 0/0/0", g_interrupt, irq_id, io_rdata); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(6);
    n_tests++; if (g_interrupt !== 1'b0) begin n_fail++; $display("FAIL rst_noreq: g_interrupt=%b expected 0", g_interrupt); end
    q.push_back(32'd0); rd(ADR_PRIO_BASE + 6'd3, got); exp = q.pop_front();
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL rst_prio: got %0h expected %0h", got, exp); end
    wr(ADR_PRIO_BASE + 6'd3, 32'd6);
    wr(ADR_ENABLE, 32'h08);
    cyc(2);
    n_tests++; if (g_interrupt !== 1'b1) begin n_fail++; $display("FAIL rst_reprog: g_interrupt=%b expected 1", g_interrupt); end
    q.push_back(32'd3); rd(ADR_CLAIM, got); exp = q.pop_front();
    n_tests++; if (got !== exp) begin n_fail++; $display("FAIL rst_insvc_clr: got %0d expected %0d", got, exp); end
  endtask

  initial begin
    rst_n    = 1'b0;
    irq_in   = '0;
    csr_meie = 1'b1;
    io_we    = 1'b0;
    io_wadr  = '0;
    io_wdata = '0;
    io_re    = 1'b0;
    io_radr  = '0;
    test_reset();
    test_edge();
    test_arb();
    test_level();
    test_boundary();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
